// File: rtl/number_pkg.sv
// rtl/number_pkg.sv - shared encodings for the decimal counter display sequencer
//
// Purpose: command opcodes, sequencer state encoding and BCD limits used by
//          number_sequencer and bcd_digit.
// Ports:   none (package).

package number_pkg;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_PAUSE = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_LOAD  = 2'd3
    } cmd_op_e;

    typedef enum logic {
        ST_PAUSED = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp a raw nibble to a legal BCD digit.
    function automatic logic [3:0] sat_bcd(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD nibble of the ripple increment/decrement chain
//
// Purpose: computes the next value of a single BCD digit when a carry (up)
//          or borrow (down) arrives, and produces the carry/borrow for the
//          next more-significant digit.
// Ports:   value      - current digit
//          down       - 1 = decrement, 0 = increment
//          carry_in   - carry/borrow from the less-significant digit
//          next_value - digit after the step
//          carry_out  - carry/borrow to the more-significant digit

module bcd_digit (
    input  logic [3:0] value,
    input  logic       down,
    input  logic       carry_in,
    output logic [3:0] next_value,
    output logic       carry_out
);
    import number_pkg::*;

    always_comb begin
        next_value = value;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (down) begin
                if (value == 4'd0) begin
                    next_value = BCD_MAX;
                    carry_out  = 1'b1;
                end else begin
                    next_value = value - 4'd1;
                end
            end else begin
                // >= rather than == so a corrupted nibble still rolls to 0
                if (value >= BCD_MAX) begin
                    next_value = 4'd0;
                    carry_out  = 1'b1;
                end else begin
                    next_value = value + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/number_sequencer.sv
// rtl/number_sequencer.sv - frame-stepped BCD counter and digit scheduler for the number renderer
//
// Purpose: detects frame starts from the beam counters, steps a DIGITS-wide
//          BCD counter every FRAMES_PER_STEP frames while running, accepts
//          run/pause/clear/load commands, and schedules which digit value and
//          x origin the shared glyph renderer draws as the beam scans.
// Ports:   clk, reset         - pixel clock, synchronous active-high reset
//          x, y               - beam hcounter / vcounter
//          cmd_valid/cmd_ready/cmd_op/cmd_data - command handshake
//          count_down         - step direction, sampled on each step
//          frame_tick         - one-cycle pulse at frame start
//          wrap               - one-cycle pulse when the counter wraps
//          running            - high while in RUN
//          digit_value/digit_x/digit_y - renderer digit and origin (one cycle behind x)
//          count              - displayed (shadow) count, updated on frame_tick

module number_sequencer #(
    parameter int DIGITS          = 4,
    parameter int FRAMES_PER_STEP = 20,
    parameter int X_ORIGIN        = 100,
    parameter int Y_ORIGIN        = 100,
    parameter int DIGIT_PITCH     = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [9:0]            y,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4*DIGITS-1:0]   cmd_data,
    input  logic                  count_down,
    output logic                  frame_tick,
    output logic                  wrap,
    output logic                  running,
    output logic [3:0]            digit_value,
    output logic [10:0]           digit_x,
    output logic [9:0]            digit_y,
    output logic [4*DIGITS-1:0]   count
);
    import number_pkg::*;

    localparam int PW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int SW  = $clog2(DIGITS + 1);
    localparam int PCW = $clog2(DIGIT_PITCH);

    state_e              state;
    logic [PW-1:0]       presc;
    logic [4*DIGITS-1:0] work;
    logic [4*DIGITS-1:0] work_next;
    logic [4*DIGITS-1:0] load_value;
    logic [DIGITS:0]     carry;
    logic                start;
    logic                start_q;
    logic                accept;
    logic                step;

    // ------------------------------------------------------------------
    // Frame detect and handshake qualifiers
    // ------------------------------------------------------------------
    assign start  = (x == 11'd0) && (y == 10'd0);
    assign accept = cmd_valid && cmd_ready;
    assign step   = (state == ST_RUN) && frame_tick &&
                    (presc == PW'(FRAMES_PER_STEP - 1));

    always_comb begin
        load_value = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_value[i*4 +: 4] = sat_bcd(cmd_data[i*4 +: 4]);
        end
    end

    // ------------------------------------------------------------------
    // BCD ripple chain: the least-significant digit always receives the
    // step, the chain's final carry is the wrap indication.
    // ------------------------------------------------------------------
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .value      (work[g*4 +: 4]),
            .down       (count_down),
            .carry_in   (carry[g]),
            .next_value (work_next[g*4 +: 4]),
            .carry_out  (carry[g+1])
        );
    end

    // ------------------------------------------------------------------
    // Control FSM, prescaler, work register and shadow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_PAUSED;
            running    <= 1'b0;
            presc      <= '0;
            work       <= '0;
            count      <= '0;
            start_q    <= 1'b0;
            frame_tick <= 1'b0;
            wrap       <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            start_q    <= start;
            frame_tick <= start && !start_q;
            // Ready drops for one cycle after every accepted command.
            cmd_ready  <= !accept;
            wrap       <= 1'b0;

            // Shadow captures the pre-step work value, giving the display
            // one frame of latency but never a mid-frame change.
            if (frame_tick) begin
                count <= work;
            end

            if ((state == ST_RUN) && frame_tick) begin
                presc <= step ? '0 : presc + 1'b1;
            end

            // Any accepted command in the same cycle discards the step.
            if (step && !accept) begin
                work <= work_next;
                wrap <= carry[DIGITS];
            end

            if (accept) begin
                case (cmd_op_e'(cmd_op))
                    CMD_RUN: begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                    CMD_PAUSE: begin
                        state   <= ST_PAUSED;
                        running <= 1'b0;
                    end
                    CMD_CLEAR: begin
                        work  <= '0;
                        presc <= '0;
                    end
                    CMD_LOAD: begin
                        work  <= load_value;
                        presc <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scheduler: slot/pitch/x-accumulator for the current x, then
    // registered outputs (one cycle behind the beam).
    // ------------------------------------------------------------------
    logic [SW-1:0]  slot;
    logic [SW-1:0]  slot_nx;
    logic [PCW-1:0] pitch;
    logic [PCW-1:0] pitch_nx;
    logic [10:0]    acc;
    logic [10:0]    acc_nx;
    logic [3:0]     sel_nibble;
    logic           in_slot;

    always_comb begin
        slot_nx  = slot;
        pitch_nx = pitch;
        acc_nx   = acc;
        if (x == 11'(X_ORIGIN)) begin
            slot_nx  = '0;
            pitch_nx = '0;
            acc_nx   = 11'(X_ORIGIN);
        end else if ((x > 11'(X_ORIGIN)) && (slot != SW'(DIGITS))) begin
            if (pitch == PCW'(DIGIT_PITCH - 1)) begin
                slot_nx  = slot + 1'b1;
                pitch_nx = '0;
                acc_nx   = acc + 11'(DIGIT_PITCH);
            end else begin
                pitch_nx = pitch + 1'b1;
            end
        end

        in_slot = (x >= 11'(X_ORIGIN)) && (slot_nx != SW'(DIGITS));

        // Slot 0 is the most-significant nibble.
        sel_nibble = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_nx == SW'(DIGITS - 1 - i)) begin
                sel_nibble = count[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot        <= '0;
            pitch       <= '0;
            acc         <= 11'(X_ORIGIN);
            digit_value <= 4'd0;
            digit_x     <= 11'(X_ORIGIN);
        end else begin
            slot  <= slot_nx;
            pitch <= pitch_nx;
            acc   <= acc_nx;
            // Outside a valid slot the last valid values are held.
            if (in_slot) begin
                digit_value <= sel_nibble;
                digit_x     <= acc_nx;
            end
        end
    end

    assign digit_y = 10'(Y_ORIGIN);

endmodule

// File: tb/tb_number_sequencer.sv
// tb/tb_number_sequencer.sv - self-checking bench for number_sequencer

module tb_number_sequencer;
    import number_pkg::*;

    localparam int D   = 4;
    localparam int F   = 2;
    localparam int XO  = 100;
    localparam int YO  = 100;
    localparam int P   = 40;
    localparam int MOD = 10000;

    logic          clk;
    logic          reset;
    logic [10:0]   x;
    logic [9:0]    y;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [15:0]   cmd_data;
    logic          count_down;
    logic          frame_tick;
    logic          wrap;
    logic          running;
    logic [3:0]    digit_value;
    logic [10:0]   digit_x;
    logic [9:0]    digit_y;
    logic [15:0]   count;

    number_sequencer #(
        .DIGITS          (D),
        .FRAMES_PER_STEP (F),
        .X_ORIGIN        (XO),
        .Y_ORIGIN        (YO),
        .DIGIT_PITCH     (P)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .count_down  (count_down),
        .frame_tick  (frame_tick),
        .wrap        (wrap),
        .running     (running),
        .digit_value (digit_value),
        .digit_x     (digit_x),
        .digit_y     (digit_y),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          exp_wrap = 0;
    int          n_wrap   = 0;
    logic [15:0] mwork    = '0;
    int          mpresc   = 0;
    bit          mrun     = 0;
    bit          tick_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            b[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic model_step();
        int v = bcd2int(mwork);
        if (count_down) begin
            if (v == 0) begin exp_wrap++; v = MOD - 1; end
            else v--;
        end else begin
            if (v == MOD - 1) begin exp_wrap++; v = 0; end
            else v++;
        end
        mwork = int2bcd(v);
    endtask

    // Scoreboard pop: the shadow is visible the cycle after frame_tick.
    always @(negedge clk) begin
        if (reset) begin
            tick_seen = 0;
        end else begin
            if (tick_seen) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                else check_eq("count_sb", 32'(count), 32'(exp_q.pop_front()));
            end
            tick_seen = frame_tick;
            if (wrap) n_wrap++;
        end
    end

    task automatic frame();
        x = 11'd0; y = 10'd0;
        exp_q.push_back(mwork);
        if (mrun) begin
            if (mpresc == F - 1) begin mpresc = 0; model_step(); end
            else mpresc++;
        end
        @(posedge clk); #1;
        x = 11'd7; y = 10'd3;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] data);
        int n = 0;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        case (op)
            2'd0: mrun = 1;
            2'd1: mrun = 0;
            2'd2: begin mwork = '0; mpresc = 0; end
            default: begin
                for (int i = 0; i < D; i++)
                    mwork[i*4 +: 4] = (data[i*4 +: 4] > 4'd9) ? 4'd9 : data[i*4 +: 4];
                mpresc = 0;
            end
        endcase
        check_eq("running", 32'(running), 32'(mrun));
        check_eq("cmd_ready_drop", 32'(cmd_ready), 32'd0);
    endtask

    // CLEAR accepted in the frame_tick cycle that also carries a step.
    task automatic clear_on_step();
        check_eq("presc_terminal", 32'(mpresc), 32'(F - 1));
        x = 11'd0; y = 10'd0;
        exp_q.push_back(mwork);
        @(posedge clk); #1;
        x = 11'd7; y = 10'd3;
        check_eq("tick_for_clear", 32'(frame_tick), 32'd1);
        cmd_valid = 1'b1; cmd_op = CMD_CLEAR; cmd_data = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        mwork = '0; mpresc = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        int acc_n;
        reset = 1'b1; x = 11'd5; y = 10'd5;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; count_down = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_frame_tick", 32'(frame_tick), 32'd0);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_digit_x", 32'(digit_x), 32'(XO));
        check_eq("rst_digit_y", 32'(digit_y), 32'(YO));
        check_eq("rst_digit_value", 32'(digit_value), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_after_reset", 32'(cmd_ready), 32'd1);

        // RUN for six frames: 0000 -> 0001 -> 0002
        send(CMD_RUN, '0);
        repeat (6) frame();
        check_eq("count_run6", 32'(count), 32'h0002);

        // Carry across three digits
        send(CMD_PAUSE, '0);
        send(CMD_LOAD, 16'h0999);
        send(CMD_RUN, '0);
        repeat (3) frame();
        check_eq("count_0999_up", 32'(count), 32'h1000);

        // Up wrap from all nines
        send(CMD_LOAD, 16'h9999);
        w0 = n_wrap;
        repeat (3) frame();
        check_eq("count_9999_up", 32'(count), 32'h0000);
        check_eq("wrap_up_pulses", 32'(n_wrap - w0), 32'd1);

        // Down wrap from zero
        count_down = 1'b1;
        w0 = n_wrap;
        repeat (2) frame();
        check_eq("count_0000_down", 32'(count), 32'h9999);
        check_eq("wrap_down_pulses", 32'(n_wrap - w0), 32'd1);
        count_down = 1'b0;

        // Load saturation
        send(CMD_LOAD, 16'h00AF);
        frame();
        check_eq("count_load_sat", 32'(count), 32'h0099);

        // Pause mid-prescale holds the prescaler
        send(CMD_PAUSE, '0);
        repeat (5) frame();
        check_eq("count_paused", 32'(count), 32'h0099);
        send(CMD_RUN, '0);
        repeat (2) frame();
        check_eq("count_after_resume", 32'(count), 32'h0100);

        // Clear beats a coincident step
        clear_on_step();
        check_eq("running_after_clear", 32'(running), 32'd1);
        frame();
        check_eq("count_clear_step", 32'(count), 32'h0000);

        // Digit scheduler sweep
        send(CMD_PAUSE, '0);
        send(CMD_LOAD, 16'h1234);
        frame();
        check_eq("count_1234", 32'(count), 32'h1234);
        y = 10'd10;
        for (int xi = 1; xi <= 300; xi++) begin
            x = 11'(xi);
            @(posedge clk); #1;
            if (xi == 99) begin
                check_eq("digit_hold_pre_x", 32'(digit_x), 32'(XO));
                check_eq("digit_hold_pre_v", 32'(digit_value), 32'd0);
            end
            if (xi >= XO && xi < XO + D * P && (xi - XO) % P == 0) begin
                check_eq("digit_value", 32'(digit_value), 32'((xi - XO) / P + 1));
                check_eq("digit_x", 32'(digit_x), 32'(XO + ((xi - XO) / P) * P));
            end
            if (xi == XO + P - 1)
                check_eq("digit_value_slot0_end", 32'(digit_value), 32'd1);
        end
        check_eq("digit_hold_value", 32'(digit_value), 32'd4);
        check_eq("digit_hold_x", 32'(digit_x), 32'(XO + 3 * P));
        x = 11'd7; y = 10'd3;
        @(posedge clk); #1;

        // Held cmd_valid: accepted every other cycle
        while (!cmd_ready) begin @(posedge clk); #1; end
        cmd_valid = 1'b1; cmd_op = CMD_PAUSE;
        acc_n = 0;
        repeat (6) begin
            if (cmd_ready) acc_n++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check_eq("held_valid_accepts", 32'(acc_n), 32'd3);
        mrun = 0;

        // Reset mid-frame with a pending command
        frame();
        x = 11'd150;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_op = CMD_RUN;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("mid_rst_running", 32'(running), 32'd0);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_digit_x", 32'(digit_x), 32'(XO));
        check_eq("mid_rst_digit_value", 32'(digit_value), 32'd0);
        check_eq("mid_rst_frame_tick", 32'(frame_tick), 32'd0);
        cmd_valid = 1'b0;
        reset = 1'b0;
        mwork = '0; mpresc = 0; mrun = 0;
        @(posedge clk); #1;

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("wrap_total", 32'(n_wrap), 32'(exp_wrap));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/number_sequencer.md
# number_sequencer

Controller for the on-screen decimal counter display. It detects frame starts from the VGA beam counters and steps a multi-digit BCD counter every FRAMES_PER_STEP frames. As the beam scans, it schedules which digit value and origin the shared `number` glyph renderer draws. It also accepts run/pause/clear/load commands over a valid/ready handshake. It sits between the `vga` timing block and the `number` renderer, on the `vga_clk` domain.

## Interface
- DIGITS, 4: number of BCD digits, 1..8.
- FRAMES_PER_STEP, 20: frames per counter step, ≥1.
- X_ORIGIN, 100: x pixel of the left edge of the most-significant digit.
- Y_ORIGIN, 100: y pixel of the top edge of all digits.
- DIGIT_PITCH, 40: horizontal pixel spacing between digit origins, ≥2.

- clk  in  1  pixel clock (`vga_clk`).
- reset  in  1  synchronous, active-high.
- x  in  11  beam hcounter.
- y  in  10  beam vcounter.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when `cmd_valid` and `cmd_ready` are both high.
- cmd_op  in  2  0 RUN, 1 PAUSE, 2 CLEAR, 3 LOAD.
- cmd_data  in  4*DIGITS  BCD load value, with digit 0 least significant in [3:0].
- count_down  in  1  1 = decrement, 0 = increment; sampled on each step.
- frame_tick  out  1  one-cycle pulse at frame start.
- wrap  out  1  one-cycle pulse when the counter wraps.
- running  out  1  high in RUN state.
- digit_value  out  4  BCD value for the renderer.
- digit_x  out  11  x origin of the current digit slot.
- digit_y  out  10  equals Y_ORIGIN.
- count  out  4*DIGITS  displayed (shadow) count.

## Operation
- **Frame detect:** `start = (x==0 && y==0)` is registered. `frame_tick` pulses on the rising edge of `start` only, so a held `start` produces a single pulse.
- **State machine:** PAUSED (reset state) and RUN.
  - RUN command: PAUSED→RUN.
  - PAUSE command: RUN→PAUSED.
  - CLEAR and LOAD do not change state.
- **Prescaler:**
  - Counts `frame_tick` in RUN only, range 0..FRAMES_PER_STEP-1.
  - At terminal count with `frame_tick`, it issues `step` and returns to 0.
  - PAUSE holds the prescaler. CLEAR and LOAD zero it.
- **BCD counter:** work register of DIGITS nibbles.
  - Up: a digit at 9 goes to 0 and carries.
  - Down: a digit at 0 goes to 9 and borrows.
  - All-9 up→0, and all-0 down→all-9. Either wrap pulses `wrap` in the same cycle the work register updates.
- **LOAD:** any nibble >9 is saturated to 9 before storing.
- **CLEAR:** sets the work register to 0.
- **Shadowing:** `count` copies the work register only on `frame_tick`, so no digit changes mid-frame.
- **Digit scheduler:**
  - Slot counter resets to 0 when x==X_ORIGIN.
  - It advances every DIGIT_PITCH pixels, counted with a pitch counter (no divider), and saturates at DIGITS.
  - Slot s selects nibble DIGITS-1-s of `count`.
  - `digit_x = X_ORIGIN + s*DIGIT_PITCH`, accumulated by adding DIGIT_PITCH per slot.
  - For x<X_ORIGIN or slot==DIGITS, outputs hold the last valid slot's values.
- **Simultaneous events:** a command accepted in the same cycle as `step` wins and the step is discarded. LOAD/CLEAR in the same cycle as `frame_tick` reaches the shadow on the next `frame_tick`.

## Timing
- **Reset values:**
  - State PAUSED; prescaler 0; work register and `count` 0; slot 0.
  - `digit_x`=X_ORIGIN; `digit_y`=Y_ORIGIN; `digit_value`=0.
  - `frame_tick`, `wrap`, `running` 0; `cmd_ready` 0.
- **cmd_ready:**
  - 1 from the first cycle after reset deasserts.
  - Drops for exactly one cycle after each accepted command, so back-to-back commands are accepted every other cycle.
- **Command latency:** a command accepted at edge N updates state and the work register at edge N, visible in cycle N+1. `running` follows in N+1.
- **Step latency:**
  - `frame_tick` is high in the cycle after the beam reaches (0,0).
  - A step updates the work register at the end of that cycle.
  - `count` therefore shows the new value at the next frame start, one frame of latency.
- **Digit outputs:** registered, one cycle behind x. The renderer must compensate by one pixel.
- **Reset mid-operation:** all state returns to reset values on the next edge. Pending handshakes are dropped.

## Structure
- Shared package `number_pkg`: `cmd_op` encodings (CMD_RUN, CMD_PAUSE, CMD_CLEAR, CMD_LOAD), state encodings, and BCD_MAX=9.
- One sub-module, `bcd_digit`: a single nibble with inc/dec/carry-in/carry-out, instantiated DIGITS times in a ripple chain.

## Test plan
- Reset, then RUN with FRAMES_PER_STEP=2 over 6 frames → `count` steps 0000→0001→0002 on the frame_ticks after every second frame; `running`=1.
- LOAD 0x0999, up → after the step and the next `frame_tick`, `count`=0x1000. LOAD 0x9999 → step gives 0x0000 with one `wrap` pulse.
- `count_down`=1 from 0x0000 → 0x9999 with `wrap`. LOAD 0x00AF → stored as 0x0099.
- PAUSE mid-prescale, then 5 frames, then RUN → step occurs after the remaining frames only. CLEAR in the same cycle as a step → work register 0, no increment.
- Beam sweep with `count`=0x1234, X_ORIGIN=100, DIGIT_PITCH=40 → `digit_value`/`digit_x` = 1/100, 2/140, 3/180, 4/220, each one cycle after x reaches the slot.
- Hold `cmd_valid` for 6 cycles → exactly 3 commands accepted. Assert reset mid-frame → all outputs reach reset values on the next edge.
